// File: rtl/axi_line_arbiter_pkg.sv
// Shared constants and state types for the cache-line AXI arbiter.
// Every burst is one cache line of 32-bit INCR beats.
package axi_line_arbiter_pkg;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [3:0] AXI_LEN_LINE   = 4'd3;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RESP} ReadState;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B} WriteState;
    typedef enum logic {OWNER_I, OWNER_D} Owner;
endpackage

// File: rtl/axi_line_arbiter_if.sv
// Cache-side request/response bundles and the five AXI channel bundles.
// Each interface exposes the view seen from the arbiter.
interface InstReq;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    modport axi (input valid, pc, output ready);
endinterface

interface InstResp;
    logic         valid;
    logic         ready;
    logic [127:0] cacheLine;
    modport axi (output valid, cacheLine, input ready);
endinterface

interface DCacheReq;
    logic         valid;
    logic         ready;
    logic [31:0]  addr;
    logic         write_en;
    logic [127:0] data;
    modport axi (input valid, addr, write_en, data, output ready);
endinterface

interface DCacheResp;
    logic         valid;
    logic         ready;
    logic [127:0] cacheLine;
    modport axi (output valid, cacheLine, input ready);
endinterface

interface AXIReadAddr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  length;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  protect;
    logic        valid;
    logic        ready;
    modport master (output id, addr, length, size, burst, lock, cache, protect, valid, input ready);
endinterface

interface AXIReadData;
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  respond;
    logic        last;
    logic        valid;
    logic        ready;
    modport master (input id, data, respond, last, valid, output ready);
endinterface

interface AXIWriteAddr;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  length;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  protect;
    logic        valid;
    logic        ready;
    modport master (output id, addr, length, size, burst, lock, cache, protect, valid, input ready);
endinterface

interface AXIWriteData;
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  strobe;
    logic        last;
    logic        valid;
    logic        ready;
    modport master (output id, data, strobe, last, valid, input ready);
endinterface

interface AXIWriteResp;
    logic [3:0] id;
    logic [1:0] respond;
    logic       valid;
    logic       ready;
    modport master (input id, respond, valid, output ready);
endinterface

// File: rtl/axi_line_writer.sv
// DCache writeback engine: one AW, LINE_WORDS W beats, then waits for B.
// busy stays high from acceptance until the B handshake.
module axi_line_writer
    import axi_line_arbiter_pkg::*;
#(
    parameter logic [3:0] D_ID       = 4'd1,
    parameter int         LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    block,
    input  logic [31:0]             req_addr,
    input  logic [32*LINE_WORDS-1:0] req_data,
    output logic                    accept,
    output logic                    busy,
    AXIWriteAddr.master             aw,
    AXIWriteData.master             w,
    AXIWriteResp.master             b
);
    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    WriteState state, next_state;
    logic [31:0]             addr;
    logic [32*LINE_WORDS-1:0] line;
    logic [CNT_W-1:0]        wcnt;
    logic                    start;
    logic                    beat;
    logic                    unused_b;

    assign start    = (state == W_IDLE) && req && !block;
    assign beat     = (state == W_DATA) && w.ready;
    assign unused_b = ^{b.id, b.respond};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= W_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            W_IDLE: if (start) next_state = W_AW;
            W_AW:   if (aw.ready) next_state = W_DATA;
            W_DATA: if (beat && wcnt == LAST_BEAT) next_state = W_B;
            W_B:    if (b.valid) next_state = W_IDLE;
            default: next_state = W_IDLE;
        endcase
    end

    always_comb begin
        aw.valid   = (state == W_AW);
        aw.id      = D_ID;
        aw.addr    = addr;
        aw.length  = AXI_LEN_LINE;
        aw.size    = AXI_SIZE_4B;
        aw.burst   = AXI_BURST_INCR;
        aw.lock    = '0;
        aw.cache   = '0;
        aw.protect = '0;
        w.valid    = (state == W_DATA);
        w.data     = line[32*wcnt +: 32];
        w.strobe   = 4'hF;
        w.id       = D_ID;
        w.last     = (wcnt == LAST_BEAT);
        b.ready    = (state == W_B);
        busy       = (state != W_IDLE);
    end

    // accept is a registered one-cycle pulse, so dReq.ready is clean during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= '0;
            line   <= '0;
            wcnt   <= '0;
            accept <= 1'b0;
        end else begin
            accept <= start;
            if (start) begin
                addr <= req_addr;
                line <= req_data;
            end
            if (beat) wcnt <= (wcnt == LAST_BEAT) ? '0 : wcnt + 1'b1;
        end
    end
endmodule

// File: rtl/axi_line_arbiter.sv
// Shares one AXI master between ICache refills and DCache refills/writebacks.
// Reads are arbitrated round-robin here; writebacks run in axi_line_writer.
module axi_line_arbiter
    import axi_line_arbiter_pkg::*;
#(
    parameter logic [3:0] I_ID       = 4'd0,
    parameter logic [3:0] D_ID       = 4'd1,
    parameter int         LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    InstReq.axi         iReq,
    InstResp.axi        iResp,
    DCacheReq.axi       dReq,
    DCacheResp.axi      dResp,
    AXIReadAddr.master  ar,
    AXIReadData.master  r,
    AXIWriteAddr.master aw,
    AXIWriteData.master w,
    AXIWriteResp.master b
);
    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    ReadState state, next_state;
    Owner                     owner, rr_last;
    logic [31:0]              addr;
    logic [CNT_W-1:0]         cnt;
    logic [32*LINE_WORDS-1:0] line;
    logic i_ready, d_ready_rd, d_ready_wr, w_busy;
    logic i_elig, d_elig, grant_i, grant_d, serving_d, beat, resp_ready;
    logic unused_bits;

    // D reads wait for any outstanding writeback to finish (read-after-write order).
    assign i_elig      = iReq.valid;
    assign d_elig      = dReq.valid && !dReq.write_en && !w_busy;
    assign grant_i     = (state == R_IDLE) && i_elig && (!d_elig || rr_last == OWNER_D);
    assign grant_d     = (state == R_IDLE) && d_elig && (!i_elig || rr_last == OWNER_I);
    assign serving_d   = (state != R_IDLE) && (owner == OWNER_D);
    assign beat        = (state == R_DATA) && r.valid;
    assign resp_ready  = (owner == OWNER_I) ? iResp.ready : dResp.ready;
    assign unused_bits = ^{r.id, r.last, r.respond, iReq.pc[3:0], dReq.addr[3:0]};

    axi_line_writer #(.D_ID(D_ID), .LINE_WORDS(LINE_WORDS)) u_writer (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (dReq.valid && dReq.write_en),
        .block    (serving_d),
        .req_addr ({dReq.addr[31:4], 4'b0}),
        .req_data (dReq.data),
        .accept   (d_ready_wr),
        .busy     (w_busy),
        .aw       (aw),
        .w        (w),
        .b        (b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= R_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            R_IDLE: if (grant_i || grant_d) next_state = R_AR;
            R_AR:   if (ar.ready) next_state = R_DATA;
            R_DATA: if (beat && cnt == LAST_BEAT) next_state = R_RESP;
            R_RESP: if (resp_ready) next_state = R_IDLE;
            default: next_state = R_IDLE;
        endcase
    end

    always_comb begin
        ar.valid        = (state == R_AR);
        ar.id           = (owner == OWNER_I) ? I_ID : D_ID;
        ar.addr         = addr;
        ar.length       = AXI_LEN_LINE;
        ar.size         = AXI_SIZE_4B;
        ar.burst        = AXI_BURST_INCR;
        ar.lock         = '0;
        ar.cache        = '0;
        ar.protect      = '0;
        r.ready         = (state == R_DATA);
        iResp.valid     = (state == R_RESP) && (owner == OWNER_I);
        dResp.valid     = (state == R_RESP) && (owner == OWNER_D);
        iResp.cacheLine = line;
        dResp.cacheLine = line;
        iReq.ready      = i_ready;
        dReq.ready      = d_ready_rd | d_ready_wr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWNER_I;
            rr_last    <= OWNER_D;
            addr       <= '0;
            cnt        <= '0;
            line       <= '0;
            i_ready    <= 1'b0;
            d_ready_rd <= 1'b0;
        end else begin
            i_ready    <= grant_i;
            d_ready_rd <= grant_d;
            if (grant_i) begin
                owner   <= OWNER_I;
                rr_last <= OWNER_I;
                addr    <= {iReq.pc[31:4], 4'b0};
            end else if (grant_d) begin
                owner   <= OWNER_D;
                rr_last <= OWNER_D;
                addr    <= {dReq.addr[31:4], 4'b0};
            end
            if (beat) begin
                line[32*cnt +: 32] <= r.data;
                cnt <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axi_line_arbiter.sv
// Directed bench for axi_line_arbiter: the bench plays both caches and the AXI slave.
module tb_axi_line_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    InstReq      ireq_if();
    InstResp     iresp_if();
    DCacheReq    dreq_if();
    DCacheResp   dresp_if();
    AXIReadAddr  ar_if();
    AXIReadData  r_if();
    AXIWriteAddr aw_if();
    AXIWriteData w_if();
    AXIWriteResp b_if();

    axi_line_arbiter #(.I_ID(4'd0), .D_ID(4'd1), .LINE_WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iReq  (ireq_if),
        .iResp (iresp_if),
        .dReq  (dreq_if),
        .dResp (dresp_if),
        .ar    (ar_if),
        .r     (r_if),
        .aw    (aw_if),
        .w     (w_if),
        .b     (b_if)
    );

    int checks = 0;
    int failures = 0;
    int dready_cnt = 0;

    function automatic logic [8:0] outs();
        return {ar_if.valid, r_if.ready, aw_if.valid, w_if.valid, b_if.ready,
                ireq_if.ready, dreq_if.ready, iresp_if.valid, dresp_if.valid};
    endfunction

    task automatic init_inputs();
        ireq_if.valid = 0; ireq_if.pc = '0; iresp_if.ready = 0;
        dreq_if.valid = 0; dreq_if.addr = '0; dreq_if.write_en = 0; dreq_if.data = '0;
        dresp_if.ready = 0; ar_if.ready = 0; aw_if.ready = 0; w_if.ready = 0;
        r_if.valid = 0; r_if.data = '0; r_if.id = '0; r_if.respond = '0; r_if.last = 0;
        b_if.valid = 0; b_if.id = '0; b_if.respond = '0;
    endtask

    // Cache model: a requester drops valid as soon as it sees its ready pulse.
    task automatic tick();
        @(posedge clk); #1;
        if (ireq_if.ready) ireq_if.valid = 0;
        if (dreq_if.ready) begin dreq_if.valid = 0; dready_cnt++; end
    endtask

    task automatic do_reset();
        init_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic feed_r(input logic [31:0] w0, w1, w2, w3, input int gap,
                          output int accepted, output bit tmo);
        logic [31:0] words [4];
        int k, guard, idle;
        bit hs;
        words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
        k = 0; guard = 0; idle = 0;
        while (k < 4 && guard < 100) begin
            if (idle > 0) begin r_if.valid = 0; r_if.data = 32'hDEAD_BEEF; idle--; end
            else begin r_if.valid = 1; r_if.data = words[k]; r_if.last = (k == 3); end
            hs = r_if.valid && r_if.ready;
            tick();
            if (hs) begin k++; idle = gap; end
            guard++;
        end
        r_if.valid = 0; r_if.last = 0;
        accepted = k; tmo = (k < 4);
    endtask

    task automatic serve_read(input logic [31:0] w0, w1, w2, w3, output logic [3:0] id,
                              output logic [31:0] a, output bit from_d,
                              output logic [127:0] line, output bit tmo);
        int n;
        bit t1;
        n = 0;
        while (!ar_if.valid && n < 40) begin tick(); n++; end
        tmo = !ar_if.valid; id = ar_if.id; a = ar_if.addr;
        ar_if.ready = 1; tick(); ar_if.ready = 0;
        feed_r(w0, w1, w2, w3, 0, n, t1);
        tmo |= t1;
        n = 0;
        while (!iresp_if.valid && !dresp_if.valid && n < 20) begin tick(); n++; end
        tmo |= !(iresp_if.valid || dresp_if.valid);
        from_d = dresp_if.valid;
        line = from_d ? dresp_if.cacheLine : iresp_if.cacheLine;
        tick();
    endtask

    task automatic test_reset();
        init_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs() !== 9'b0) begin failures++; $display("FAIL reset_outputs got=%b want=000000000", outs()); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_icache_read();
        int n;
        bit tmo;
        iresp_if.ready = 0;
        ireq_if.pc = 32'hBFC0_0004; ireq_if.valid = 1;
        n = 0;
        while (!ar_if.valid && n < 20) begin tick(); n++; end
        checks++;
        if (!ar_if.valid) begin failures++; $display("FAIL i_ar_timeout got=0 want=1"); end
        checks++;
        if (ar_if.addr !== 32'hBFC0_0000) begin failures++; $display("FAIL i_ar_addr got=%h want=bfc00000", ar_if.addr); end
        checks++;
        if ({ar_if.id, ar_if.length, ar_if.size, ar_if.burst} !== {4'd0, 4'd3, 3'b010, 2'b01}) begin
            failures++; $display("FAIL i_ar_fields got=%h/%h/%b/%b want=0/3/010/01", ar_if.id, ar_if.length, ar_if.size, ar_if.burst);
        end
        ar_if.ready = 1; tick(); ar_if.ready = 0;
        checks++;
        if (ar_if.valid !== 1'b0) begin failures++; $display("FAIL i_ar_drop got=%b want=0", ar_if.valid); end
        feed_r(32'h11, 32'h22, 32'h33, 32'h44, 0, n, tmo);
        checks++;
        if (iresp_if.valid !== 1'b1 || iresp_if.cacheLine !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
            failures++; $display("FAIL i_resp_line got=%b/%h want=1/00000044000000330000002200000011", iresp_if.valid, iresp_if.cacheLine);
        end
        repeat (2) tick();
        checks++;
        if (iresp_if.valid !== 1'b1 || iresp_if.cacheLine !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
            failures++; $display("FAIL i_resp_hold got=%b/%h want=1/line", iresp_if.valid, iresp_if.cacheLine);
        end
        iresp_if.ready = 1; tick();
        checks++;
        if (iresp_if.valid !== 1'b0) begin failures++; $display("FAIL i_resp_release got=%b want=0", iresp_if.valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] id;
        logic [31:0] a;
        logic [127:0] line;
        bit from_d, tmo;
        do_reset();
        iresp_if.ready = 1; dresp_if.ready = 1;
        for (int rep = 0; rep < 2; rep++) begin
            ireq_if.pc = 32'h0000_1004 + 32'(rep) * 32'h100; ireq_if.valid = 1;
            dreq_if.addr = 32'h0000_2008; dreq_if.write_en = 0; dreq_if.valid = 1;
            serve_read(32'h1, 32'h2, 32'h3, 32'h4, id, a, from_d, line, tmo);
            checks++;
            if (tmo || id !== 4'd0 || a !== (32'h0000_1000 + 32'(rep) * 32'h100)) begin
                failures++; $display("FAIL rr_first_%0d got=id%h addr%h tmo%0d want=id0 addr%h", rep, id, a, tmo, 32'h0000_1000 + 32'(rep) * 32'h100);
            end
            checks++;
            if (from_d || line !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
                failures++; $display("FAIL rr_first_line_%0d got=d%0d %h want=d0 00000004000000030000000200000001", rep, from_d, line);
            end
            serve_read(32'h5, 32'h6, 32'h7, 32'h8, id, a, from_d, line, tmo);
            checks++;
            if (tmo || id !== 4'd1 || a !== 32'h0000_2000) begin
                failures++; $display("FAIL rr_second_%0d got=id%h addr%h tmo%0d want=id1 addr00002000", rep, id, a, tmo);
            end
            checks++;
            if (!from_d || line !== {32'h8, 32'h7, 32'h6, 32'h5}) begin
                failures++; $display("FAIL rr_second_line_%0d got=d%0d %h want=d1 00000008000000070000000600000005", rep, from_d, line);
            end
        end
    endtask

    task automatic test_dcache_write();
        logic [31:0] seen [4];
        logic [3:0] last_seen;
        bit strb_ok, saw_dresp;
        int n, k;
        dready_cnt = 0; strb_ok = 1; saw_dresp = 0; last_seen = '0;
        dreq_if.addr = 32'h8000_0010; dreq_if.data = {32'hD, 32'hC, 32'hB, 32'hA};
        dreq_if.write_en = 1; dreq_if.valid = 1;
        n = 0;
        while (!aw_if.valid && n < 20) begin tick(); n++; end
        checks++;
        if (aw_if.addr !== 32'h8000_0010 || !aw_if.valid) begin failures++; $display("FAIL w_aw_addr got=%h valid%b want=80000010", aw_if.addr, aw_if.valid); end
        checks++;
        if ({aw_if.id, aw_if.length, aw_if.size, aw_if.burst} !== {4'd1, 4'd3, 3'b010, 2'b01}) begin
            failures++; $display("FAIL w_aw_fields got=%h/%h/%b/%b want=1/3/010/01", aw_if.id, aw_if.length, aw_if.size, aw_if.burst);
        end
        aw_if.ready = 1; tick(); aw_if.ready = 0;
        w_if.ready = 1; k = 0; n = 0;
        while (k < 4 && n < 20) begin
            if (w_if.valid) begin
                seen[k] = w_if.data; last_seen[k] = w_if.last;
                if (w_if.strobe !== 4'hF || w_if.id !== 4'd1) strb_ok = 0;
                k++;
            end
            tick(); n++;
            if (dresp_if.valid) saw_dresp = 1;
        end
        w_if.ready = 0;
        checks++;
        if (k != 4) begin failures++; $display("FAIL w_beat_count got=%0d want=4", k); end
        for (int i = 0; i < k; i++) begin
            checks++;
            if (seen[i] !== 32'hA + 32'(i)) begin failures++; $display("FAIL w_beat_%0d got=%h want=%h", i, seen[i], 32'hA + 32'(i)); end
        end
        checks++;
        if (last_seen !== 4'b1000 || !strb_ok) begin failures++; $display("FAIL w_last_strobe got=%b/%0d want=1000/1", last_seen, strb_ok); end
        tick();
        checks++;
        if (b_if.ready !== 1'b1 || w_if.valid !== 1'b0) begin failures++; $display("FAIL w_b_wait got=bready%b wvalid%b want=1/0", b_if.ready, w_if.valid); end
        b_if.valid = 1; tick(); b_if.valid = 0;
        checks++;
        if (b_if.ready !== 1'b0 || aw_if.valid !== 1'b0) begin failures++; $display("FAIL w_b_done got=bready%b awvalid%b want=0/0", b_if.ready, aw_if.valid); end
        checks++;
        if (dready_cnt != 1 || saw_dresp) begin failures++; $display("FAIL w_dready_pulses got=%0d dresp%0d want=1 dresp0", dready_cnt, saw_dresp); end
    endtask

    task automatic test_write_then_read();
        logic [3:0] id;
        logic [31:0] a;
        logic [127:0] line;
        bit from_d, tmo, early;
        int n, k;
        dready_cnt = 0; early = 0;
        iresp_if.ready = 1; dresp_if.ready = 1;
        dreq_if.addr = 32'h8000_0040; dreq_if.data = {32'h44, 32'h33, 32'h22, 32'h11};
        dreq_if.write_en = 1; dreq_if.valid = 1;
        n = 0;
        while (dready_cnt == 0 && n < 20) begin tick(); n++; end
        dreq_if.write_en = 0; dreq_if.addr = 32'h9000_0000; dreq_if.valid = 1;
        repeat (3) begin tick(); if (ar_if.valid) early = 1; end
        aw_if.ready = 1; tick(); aw_if.ready = 0;
        ireq_if.pc = 32'h3000_0010; ireq_if.valid = 1;
        n = 0;
        while (!ar_if.valid && n < 20) begin tick(); n++; end
        checks++;
        if (ar_if.valid !== 1'b1 || ar_if.id !== 4'd0 || w_if.valid !== 1'b1) begin
            failures++; $display("FAIL raw_i_during_w got=arvalid%b id%h wvalid%b want=1/0/1", ar_if.valid, ar_if.id, w_if.valid);
        end
        serve_read(32'h21, 32'h22, 32'h23, 32'h24, id, a, from_d, line, tmo);
        checks++;
        if (tmo || from_d || a !== 32'h3000_0010 || line !== {32'h24, 32'h23, 32'h22, 32'h21}) begin
            failures++; $display("FAIL raw_i_line got=tmo%0d d%0d addr%h %h want=0/0/30000010", tmo, from_d, a, line);
        end
        w_if.ready = 1; k = 0; n = 0;
        while (k < 4 && n < 20) begin
            if (w_if.valid) k++;
            if (ar_if.valid) early = 1;
            tick(); n++;
        end
        w_if.ready = 0;
        repeat (3) begin tick(); if (ar_if.valid) early = 1; end
        checks++;
        if (early || b_if.ready !== 1'b1) begin failures++; $display("FAIL raw_no_d_ar_before_b got=early%0d bready%b want=0/1", early, b_if.ready); end
        b_if.valid = 1; tick(); b_if.valid = 0;
        serve_read(32'h31, 32'h32, 32'h33, 32'h34, id, a, from_d, line, tmo);
        checks++;
        if (tmo || id !== 4'd1 || a !== 32'h9000_0000 || !from_d || line !== {32'h34, 32'h33, 32'h32, 32'h31}) begin
            failures++; $display("FAIL raw_d_after_b got=tmo%0d id%h addr%h d%0d %h want=0/1/90000000/1", tmo, id, a, from_d, line);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_line;
        bit stable, tmo;
        int n;
        iresp_if.ready = 0;
        exp_line = {32'hCAFE_0004, 32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001};
        ireq_if.pc = 32'h0000_1234; ireq_if.valid = 1;
        n = 0;
        while (!ar_if.valid && n < 20) begin tick(); n++; end
        stable = ar_if.valid;
        repeat (5) begin
            tick();
            if (ar_if.valid !== 1'b1 || ar_if.addr !== 32'h0000_1230) stable = 0;
        end
        checks++;
        if (!stable) begin failures++; $display("FAIL bp_ar_stable got=valid%b addr%h want=1/00001230", ar_if.valid, ar_if.addr); end
        ar_if.ready = 1; tick(); ar_if.ready = 0;
        feed_r(32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'hCAFE_0004, 2, n, tmo);
        checks++;
        if (n != 4 || tmo) begin failures++; $display("FAIL bp_beats got=%0d want=4", n); end
        r_if.valid = 1; r_if.data = 32'hBAD0_0000;
        checks++;
        if (r_if.ready !== 1'b0) begin failures++; $display("FAIL bp_extra_beat got=rready%b want=0", r_if.ready); end
        tick(); r_if.valid = 0;
        stable = 1;
        repeat (3) begin
            if (iresp_if.valid !== 1'b1 || iresp_if.cacheLine !== exp_line) stable = 0;
            tick();
        end
        checks++;
        if (!stable || iresp_if.valid !== 1'b1 || iresp_if.cacheLine !== exp_line) begin
            failures++; $display("FAIL bp_resp_hold got=%b/%h want=1/%h", iresp_if.valid, iresp_if.cacheLine, exp_line);
        end
        iresp_if.ready = 1; tick();
        checks++;
        if (iresp_if.valid !== 1'b0) begin failures++; $display("FAIL bp_resp_release got=%b want=0", iresp_if.valid); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] id;
        logic [31:0] a;
        logic [127:0] line;
        bit from_d, tmo;
        int n;
        iresp_if.ready = 1;
        ireq_if.pc = 32'h4000_0000; ireq_if.valid = 1;
        n = 0;
        while (!ar_if.valid && n < 20) begin tick(); n++; end
        ar_if.ready = 1; tick(); ar_if.ready = 0;
        r_if.valid = 1; r_if.data = 32'h71; tick();
        r_if.data = 32'h72; tick();
        r_if.valid = 0;
        checks++;
        if (r_if.ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_burst got=rready%b want=1", r_if.ready); end
        rst_n = 0;
        #1;
        checks++;
        if (outs() !== 9'b0) begin failures++; $display("FAIL rst_mid_async got=%b want=000000000", outs()); end
        @(negedge clk);
        rst_n = 1;
        tick();
        ireq_if.pc = 32'h5000_0020; ireq_if.valid = 1;
        serve_read(32'h1, 32'h2, 32'h3, 32'h4, id, a, from_d, line, tmo);
        checks++;
        if (tmo || id !== 4'd0 || a !== 32'h5000_0020 || from_d || line !== {32'h4, 32'h3, 32'h2, 32'h1}) begin
            failures++; $display("FAIL rst_mid_fresh got=tmo%0d id%h addr%h d%0d %h want=0/0/50000020/0", tmo, id, a, from_d, line);
        end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_icache_read();
        test_round_robin();
        test_dcache_write();
        test_write_then_read();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_line_arbiter.md
Name: axi_line_arbiter

Overview:
- Shares the single AXI master port between ICache line refills (InstReq/InstResp) and DCache line refills and writebacks (DCacheReq/DCacheResp).
- Turns each request into one 4-beat INCR burst of 32-bit beats.
- Reads and writes run on independent FSMs.
- Sits between the cache subsystem and the SoC AXI interconnect.

Parameters:
- I_ID, 4'd0, AXI id used for ICache reads
- D_ID, 4'd1, AXI id used for DCache reads and writes
- LINE_WORDS, 4, words per line; AXI length = LINE_WORDS-1

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active-low
- iReq  InstReq.axi  intf  ICache refill request (pc)
- iResp  InstResp.axi  intf  ICache line return (128-bit cacheLine)
- dReq  DCacheReq.axi  intf  DCache read or writeback request (addr, write_en, 128-bit data)
- dResp  DCacheResp.axi  intf  DCache read line return
- ar  AXIReadAddr.master  intf
- r  AXIReadData.master  intf
- aw  AXIWriteAddr.master  intf
- w  AXIWriteData.master  intf
- b  AXIWriteResp.master  intf

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - All valid/ready outputs 0; both FSMs IDLE.
  - Beat counters 0; line buffers 0; rr_last=D, so ICache wins the first tie.
- AR constant fields: size 3'b010, burst 2'b01, lock 0, cache 0, protect 0, length 4'd3. Address is {addr[31:4],4'b0}; low 4 bits are ignored.
- Read FSM states: R_IDLE, R_AR, R_DATA, R_RESP.
- R_IDLE, grant decision:
  - Eligible requesters: iReq.valid; and dReq.valid with write_en=0, only while the write FSM is W_IDLE.
  - Only one eligible: grant it. Both eligible: grant the one not equal to rr_last, then update rr_last.
  - On grant: latch address and owner, pulse the winner's ready for exactly 1 cycle, go to R_AR.
  - No eligible request: stay.
- R_AR: ar.valid=1, id from owner. On ar.ready go to R_DATA; ar.valid drops the next cycle.
- R_DATA:
  - r.ready=1. Each r.valid&&r.ready writes r.data into line[32*cnt +: 32], then cnt++.
  - When the beat with cnt==3 is accepted, go to R_RESP and clear cnt.
  - r.last is not used for termination. r.respond is ignored.
- R_RESP:
  - Owner's resp valid=1 with the assembled line, held stable until the owner's resp ready is sampled high, then R_IDLE.
  - If ready is already high, valid lasts 1 cycle.
  - A new grant is never made in the same cycle as the response handshake; the next grant is earliest the following cycle.
- Write FSM states: W_IDLE, W_AW, W_DATA, W_B.
- W_IDLE: when dReq.valid && write_en and the read FSM is not serving a D read:
  - Latch line-aligned address and 128-bit data.
  - Pulse dReq.ready for 1 cycle; go to W_AW.
  - No dResp is produced for writes.
- W_AW: aw.valid=1, fields as for AR, id=D_ID. On aw.ready go to W_DATA.
- W_DATA:
  - w.valid=1, w.data=line[32*wcnt +: 32], strobe 4'hF, id D_ID, w.last=(wcnt==3).
  - On w.ready: wcnt++. After the last beat, go to W_B.
- W_B: b.ready=1; on b.valid go to W_IDLE. b.respond is ignored.
- dReq.ready arbitration:
  - dReq.ready is driven by whichever FSM accepts the request; the two are mutually exclusive by construction.
  - Read and write for D are never accepted in the same cycle.
  - A D read waits while a writeback is outstanding up to the B response (RAW ordering). I reads proceed in parallel with writes.
- Back-to-back: a requester holding valid after its response is re-arbitrated normally.
- Reset mid-operation: everything is cleared immediately. The outstanding AXI transaction is abandoned; this is a system-wide reset.

Decomposition:
- Package defs:
  - AXI constants AXI_BURST_INCR, AXI_SIZE_4B, AXI_LEN_LINE.
  - Enums ReadState and WriteState.
  - Owner type (OWNER_I / OWNER_D).
- Sub-module axi_line_writer: holds the write FSM and exports busy. The top level holds the read FSM and arbitration.

Test Plan:
- ICache read only, pc=32'hBFC0_0004:
  - Expected AR: addr 32'hBFC0_0000, id 0, len 3.
  - Feed R words 11,22,33,44 → iResp.cacheLine = {44,33,22,11}, valid held until ready.
- iReq and dReq read asserted in the same cycle after reset:
  - I is granted first (AR id 0), then D (id 1).
  - Repeat both again → I then D again. Alternation holds: rr_last=D after the second grant.
- DCache write, addr 32'h8000_0010, data {D,C,B,A}:
  - Expected AW addr 32'h8000_0010; W beats A,B,C,D with last only on beat 4; strobe F; b.ready until B.
  - dReq.ready pulses once, at acceptance.
- DCache write then immediate DCache read:
  - No AR id 1 before b.valid is received.
  - An ICache read issued meanwhile gets its AR during W_DATA.
- AXI backpressure:
  - ar.ready is delayed 5 cycles; r.valid gaps between beats.
  - Expected: ar.valid stable, data order correct, exactly 4 beats consumed.
  - The response waits 3 cycles of resp ready=0 with stable data.
- Reset mid-burst:
  - Assert rst_n low after beat 2.
  - Expected, asynchronously: all valid/ready outputs 0.
  - After release, a fresh request completes with counters starting at 0.
